// File: rtl/pwm_breather.sv
// Strobe-paced LED breathing engine: a duty-cycle FSM (rise, hold, fall, hold)
// advanced by single-cycle strobes, driving a free-running PWM comparator.
module pwm_breather #(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1,
  parameter int unsigned HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic         enable,
  output logic         led,
  output logic [W-1:0] duty,
  output logic [2:0]   phase
);

  localparam logic [W-1:0]  MAX       = {W{1'b1}};
  localparam int unsigned   HW_RAW    = $clog2(HOLD + 1);
  localparam int unsigned   HW        = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam logic [W:0]    STEP_X    = (W+1)'(STEP);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE   = 3'd1,
    TOP    = 3'd2,
    FALL   = 3'd3,
    BOTTOM = 3'd4
  } state_e;

  state_e        state_q;
  logic [W-1:0]  duty_q;
  logic [HW-1:0] hold_q;
  logic [W-1:0]  pwm_cnt_q;
  logic          led_q;

  // Ramp arithmetic is done one bit wider so the end points saturate, never wrap.
  logic [W:0]    rise_sum_d;
  logic          rise_sat_d;
  logic          fall_floor_d;
  logic [W-1:0]  fall_diff_d;
  logic          hold_done_d;

  always_comb begin
    rise_sum_d   = {1'b0, duty_q} + STEP_X;
    rise_sat_d   = (rise_sum_d >= {1'b0, MAX});
    fall_floor_d = ({1'b0, duty_q} <= STEP_X);
    fall_diff_d  = duty_q - STEP_X[W-1:0];
    hold_done_d  = (hold_q == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
    end else if (!enable) begin
      // Dropping enable wins over any coincident strobe.
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RISE;
        end
        RISE: begin
          if (strobe) begin
            if (rise_sat_d) begin
              duty_q  <= MAX;
              state_q <= TOP;
              hold_q  <= '0;
            end else begin
              duty_q <= rise_sum_d[W-1:0];
            end
          end
        end
        TOP: begin
          if (strobe) begin
            if (hold_done_d) begin
              state_q <= FALL;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        FALL: begin
          if (strobe) begin
            if (fall_floor_d) begin
              duty_q  <= '0;
              state_q <= BOTTOM;
              hold_q  <= '0;
            end else begin
              duty_q <= fall_diff_d;
            end
          end
        end
        BOTTOM: begin
          if (strobe) begin
            if (hold_done_d) begin
              state_q <= RISE;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          duty_q  <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // The PWM counter free-runs regardless of enable; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      led_q     <= enable & (pwm_cnt_q < duty_q);
    end
  end

  assign led   = led_q;
  assign duty  = duty_q;
  assign phase = state_q;

endmodule

// File: doc/pwm_breather.md
# pwm_breather

Strobe-paced LED brightness "breathing" engine that consumes the single-cycle `strobe` pulse produced by the periodic strobe generator. Each strobe advances a duty-cycle state machine: ramp up, hold at full brightness, ramp down, hold at dark, repeat. A free-running PWM counter then turns the current duty into a registered LED drive. It sits between the strobe generator and a board LED pin in the power-lab designs.

## Interface
- `W`, 8: PWM and duty resolution in bits; MAX = 2^W − 1.
- `STEP`, 1: duty increment/decrement per strobe; 1 ≤ STEP ≤ MAX.
- `HOLD`, 4: number of strobes spent in TOP and in BOTTOM; HOLD ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `strobe`  in  1  single-cycle advance pulse, synchronous to `clk`.
- `enable`  in  1  level; high runs the breathing cycle, low forces dark/IDLE.
- `led`  out  1  registered PWM output.
- `duty`  out  W  current duty value, registered.
- `phase`  out  3  current FSM state encoding.

## Operation
- States and `phase` encoding: IDLE=0, RISE=1, TOP=2, FALL=3, BOTTOM=4. Codes 5–7 are unused; if one is ever reached, the next state is IDLE.
- Reset (asynchronous, `rst_n` low): state IDLE, `duty`=0, hold counter=0, PWM counter=0, `led`=0. The same values apply if reset is asserted mid-ramp.
- `enable` low, in any state, at a clock edge: next state IDLE, `duty`←0, hold counter←0. This overrides a coincident `strobe`.
- IDLE with `enable` high: go to RISE on the next edge without waiting for a strobe. `duty` stays 0.
- RISE, on strobe:
  - if duty + STEP ≥ MAX (computed in W+1 bits, no wrap): `duty`←MAX, go to TOP, hold counter←0.
  - otherwise `duty`←duty+STEP.
- TOP, on strobe: increment the hold counter. On the HOLD-th strobe, go to FALL and clear the hold counter. `duty` stays MAX.
- FALL, on strobe:
  - if duty ≤ STEP: `duty`←0, go to BOTTOM, hold counter←0.
  - otherwise `duty`←duty−STEP. No underflow wrap is allowed.
- BOTTOM, on strobe: count HOLD strobes as in TOP, then go to RISE. `duty` stays 0.
- Without a strobe, no state or duty change occurs, except the `enable`/IDLE rules above.
- PWM:
  - W-bit counter increments every clock and wraps MAX→0.
  - `led` ← enable AND (pwm_cnt < duty), registered.
  - duty=0 gives `led` always 0; duty=MAX gives `led` high for MAX of every 2^W cycles.
- Hold counter width is ceil(log2(HOLD+1)) bits, minimum 1.

## Timing
- A strobe sampled at edge n updates `duty`/`phase` at edge n. The first `led` value computed from the new duty appears at edge n+1.
- `enable` falling, sampled at edge n: `duty`=0 and `phase`=0 after edge n; `led`=0 from edge n on (gated by enable in the same registration).
- Full breathing period: 2·(ceil(MAX/STEP) + HOLD) strobes.
- Back-to-back strobes on consecutive cycles are legal; each one advances exactly one step.
- The PWM counter runs independently of the state machine and is never reset by `enable`.

## Test plan
- Reset mid-operation: W=4, STEP=1, HOLD=2. Run to duty=7 in RISE, pulse `rst_n` low asynchronously between edges → `duty`=0, `phase`=0, `led`=0 immediately; after release, IDLE→RISE on the first edge with `enable`=1.
- Full cycle, same parameters, `enable`=1, a strobe every 20 clocks:
  - strobes 1–15 → duty 1..15; strobe 15 enters TOP (phase=2).
  - strobes 16–17 → FALL.
  - strobes 18–32 → duty 14..0; strobe 32 enters BOTTOM.
  - strobes 33–34 → RISE.
  - Period = 34 strobes.
- Saturation, W=4, STEP=6:
  - RISE duty 0→6→12→15, then TOP.
  - FALL 15→9→3→0, then BOTTOM. No wrap at either end.
- PWM accuracy: hold duty=5 with no strobes (W=4) → `led` high exactly 5 of any 16 consecutive cycles. duty=0 → 0 of 16. duty=15 → 15 of 16.
- Enable priority: assert `strobe` and drop `enable` on the same edge while in RISE at duty=9 → `phase`=0, `duty`=0, no duty=10 step. Re-raising `enable` restarts in RISE from 0.
- Back-to-back strobes: 3 consecutive single-cycle strobes from duty=2 (STEP=1) → duty 3, 4, 5 on successive edges.
